// File: rtl/spi_voice_pkg.sv
// Shared definitions for the SPI voice register block.
//  - CMD_* header command encodings
//  - payload field widths and LSB offsets (payload LSB = progn bit)
//  - FSM state enum
//  - width helpers for voice index and payload
package spi_voice_pkg;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_BCAST = 2'b10;
  localparam logic [1:0] CMD_TRIG  = 2'b11;

  localparam int CMD_W   = 2;
  localparam int FIELD_W = 8;   // ADSR and filter coefficient fields
  localparam int FIXED_W = 49;  // payload bits excluding osc_count

  // Fixed LSB offsets; fields above osc_count move with OSC_W.
  localparam int OFS_PROGN = 0;
  localparam int OFS_FB    = 1;
  localparam int OFS_FA    = 9;
  localparam int OFS_OSC   = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_COMMIT
  } st_e;

  function automatic int voice_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pay_w(input int osc_w);
    return FIXED_W + osc_w;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame bit collector: PAY_W-deep shift register, saturating bit counter
// and overflow flag. Every frame bit (header included) is shifted in, so
// once a full-length frame has arrived the register holds exactly the
// payload; the header has fallen off the top.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  start_i         first bit of a frame (restarts count)
//  shift_i         subsequent frame bit valid
//  bit_i           serial bit
//  sr_o            last PAY_W bits received
//  cnt_o           bits received, saturating at FRAME_W
//  ovf_o           a bit arrived after FRAME_W bits were already in
module spi_frame_shifter #(
  parameter int PAY_W   = 61,
  parameter int FRAME_W = 65,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [PAY_W-1:0] sr_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W);

  logic [PAY_W-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_i) begin
      sr_q  <= {{(PAY_W-1){1'b0}}, bit_i};
      cnt_q <= CNT_W'(1);
      ovf_q <= 1'b0;
    end else if (shift_i) begin
      // Extra bits only flag overflow so the captured payload stays intact.
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        sr_q  <= {sr_q[PAY_W-2:0], bit_i};
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sr_o  = sr_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/spi_voice_regs.sv
// Multi-voice SPI configuration receiver. Clock-synchronous frames (one
// bit per clk while nss low, MSB first) carry a header {CMD, VOICE} and
// an optional payload {ai,di,s,ri,osc_count,filter_a,filter_b,progn}.
// The payload is collected in a shadow shift register and copied into
// the target voice bank(s) in one cycle after nss rises, so each voice
// updates atomically.
// Optional feature macro: SPI_READBACK_EN (adds miso port and CMD 00 read).
// Ports:
//  clk, rst                         clock, synchronous active-high reset
//  nss, mosi                        frame select (active low), serial data in
//  miso                             readback data (SPI_READBACK_EN only)
//  adsr_ai/di/s/ri                  per-voice ADSR, voice v at [8v+7:8v]
//  osc_count                        per-voice oscillator count
//  filter_a/filter_b                per-voice filter coefficients
//  progn                            per-voice program mode, active low
//  trig                             one-cycle trigger pulse per voice
//  frame_err                        one-cycle pulse on a rejected frame
module spi_voice_regs
  import spi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int OSC_W      = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        nss,
  input  logic                        mosi,
`ifdef SPI_READBACK_EN
  output logic                        miso,
`endif
  output logic [8*NUM_VOICES-1:0]     adsr_ai,
  output logic [8*NUM_VOICES-1:0]     adsr_di,
  output logic [8*NUM_VOICES-1:0]     adsr_s,
  output logic [8*NUM_VOICES-1:0]     adsr_ri,
  output logic [OSC_W*NUM_VOICES-1:0] osc_count,
  output logic [8*NUM_VOICES-1:0]     filter_a,
  output logic [8*NUM_VOICES-1:0]     filter_b,
  output logic [NUM_VOICES-1:0]       progn,
  output logic [NUM_VOICES-1:0]       trig,
  output logic                        frame_err
);

  localparam int VOICE_W = voice_w(NUM_VOICES);
  localparam int HDR_W   = CMD_W + VOICE_W;
  localparam int PAY_W   = pay_w(OSC_W);
  localparam int FRAME_W = HDR_W + PAY_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam int OFS_RI = OFS_OSC + OSC_W;
  localparam int OFS_S  = OFS_RI + FIELD_W;
  localparam int OFS_DI = OFS_S + FIELD_W;
  localparam int OFS_AI = OFS_DI + FIELD_W;

  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_HDR      = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);

  st_e                   state_q;
  logic                  armed_q;
  logic [HDR_W-1:0]      hdr_q;
  logic [NUM_VOICES-1:0] wr_mask_q, trig_mask_q;
  logic                  err_pend_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic                  frame_err_q;

  logic [NUM_VOICES-1:0][FIELD_W-1:0] ai_q, di_q, s_q, ri_q, fa_q, fb_q;
  logic [NUM_VOICES-1:0][OSC_W-1:0]   osc_q;
  logic [NUM_VOICES-1:0]              progn_q;

  logic [PAY_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             start, shift;

  // A frame may only begin once nss has been seen high, so a select held
  // low through reset release or a reset-aborted frame is ignored.
  assign start = (state_q == ST_IDLE) && armed_q && !nss;
  assign shift = ((state_q == ST_HDR) || (state_q == ST_DATA)) && !nss;

  spi_frame_shifter #(
    .PAY_W  (PAY_W),
    .FRAME_W(FRAME_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .shift_i(shift),
    .bit_i  (mosi),
    .sr_o   (sr),
    .cnt_o  (cnt),
    .ovf_o  (ovf)
  );

  // Header decode and frame verdict (only meaningful in DATA on nss rise).
  logic [CMD_W-1:0]      cmd;
  logic [VOICE_W-1:0]    vsel;
  logic [NUM_VOICES-1:0] vhot;
  logic                  voice_ok, len_full, len_hdr;
  logic [NUM_VOICES-1:0] wr_mask_d, trig_mask_d;
  logic                  err_d;

  assign cmd      = hdr_q[HDR_W-1 -: CMD_W];
  assign vsel     = hdr_q[VOICE_W-1:0];
  assign len_full = !ovf && (cnt == CNT_FRAME);
  assign len_hdr  = !ovf && (cnt == CNT_HDR);

  always_comb begin
    vhot     = '0;
    voice_ok = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vsel == VOICE_W'(v)) begin
        vhot[v]  = 1'b1;
        voice_ok = 1'b1;
      end
    end
  end

  always_comb begin
    wr_mask_d   = '0;
    trig_mask_d = '0;
    err_d       = 1'b1;
    unique case (cmd)
      CMD_WRITE: if (len_full && voice_ok) begin
        wr_mask_d   = vhot;
        trig_mask_d = vhot;
        err_d       = 1'b0;
      end
      CMD_BCAST: if (len_full) begin
        wr_mask_d   = '1;
        trig_mask_d = '1;
        err_d       = 1'b0;
      end
      CMD_TRIG: if (len_hdr && voice_ok) begin
        trig_mask_d = vhot;
        err_d       = 1'b0;
      end
`ifdef SPI_READBACK_EN
      CMD_READ: if (len_full && voice_ok) begin
        err_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      hdr_q       <= '0;
      wr_mask_q   <= '0;
      trig_mask_q <= '0;
      err_pend_q  <= 1'b0;
      trig_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      trig_q      <= '0;
      frame_err_q <= 1'b0;
      if (nss) armed_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: if (start) begin
          armed_q <= 1'b0;
          hdr_q   <= {{(HDR_W-1){1'b0}}, mosi};
          state_q <= ST_HDR;
        end
        ST_HDR: begin
          if (nss) begin
            // Frame ended inside the header: always rejected.
            wr_mask_q   <= '0;
            trig_mask_q <= '0;
            err_pend_q  <= 1'b1;
            state_q     <= ST_COMMIT;
          end else begin
            hdr_q <= {hdr_q[HDR_W-2:0], mosi};
            if (cnt == CNT_HDR_LAST) state_q <= ST_DATA;
          end
        end
        ST_DATA: if (nss) begin
          wr_mask_q   <= wr_mask_d;
          trig_mask_q <= trig_mask_d;
          err_pend_q  <= err_d;
          state_q     <= ST_COMMIT;
        end
        ST_COMMIT: begin
          trig_q      <= trig_mask_q;
          frame_err_q <= err_pend_q;
          wr_mask_q   <= '0;
          trig_mask_q <= '0;
          err_pend_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Voice banks: copied from the shadow register in the commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ai_q    <= '0;
      di_q    <= '0;
      s_q     <= '0;
      ri_q    <= '0;
      osc_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      progn_q <= '1;
    end else if (state_q == ST_COMMIT) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_mask_q[v]) begin
          ai_q[v]    <= sr[OFS_AI +: FIELD_W];
          di_q[v]    <= sr[OFS_DI +: FIELD_W];
          s_q[v]     <= sr[OFS_S +: FIELD_W];
          ri_q[v]    <= sr[OFS_RI +: FIELD_W];
          osc_q[v]   <= sr[OFS_OSC +: OSC_W];
          fa_q[v]    <= sr[OFS_FA +: FIELD_W];
          fb_q[v]    <= sr[OFS_FB +: FIELD_W];
          progn_q[v] <= sr[OFS_PROGN];
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  // Readback: the target voice is snapshotted into an output shift register
  // on the last header bit; miso then presents one payload bit per data
  // cycle, MSB first, and returns to 0 once the payload is exhausted.
  logic [HDR_W-1:0]   hdr_nxt;
  logic [VOICE_W-1:0] vsel_nxt;
  logic [PAY_W-1:0]   rd_sel, rd_load, rd_sr_q;
  logic               miso_q;

  assign hdr_nxt  = {hdr_q[HDR_W-2:0], mosi};
  assign vsel_nxt = hdr_nxt[VOICE_W-1:0];

  always_comb begin
    rd_sel = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vsel_nxt == VOICE_W'(v))
        rd_sel = {ai_q[v], di_q[v], s_q[v], ri_q[v], osc_q[v],
                  fa_q[v], fb_q[v], progn_q[v]};
    end
    rd_load = (hdr_nxt[HDR_W-1 -: CMD_W] == CMD_READ) ? rd_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr_q <= '0;
      miso_q  <= 1'b0;
    end else begin
      miso_q <= 1'b0;
      if ((state_q == ST_HDR) && !nss && (cnt == CNT_HDR_LAST)) begin
        miso_q  <= rd_load[PAY_W-1];
        rd_sr_q <= {rd_load[PAY_W-2:0], 1'b0};
      end else if ((state_q == ST_DATA) && !nss) begin
        miso_q  <= rd_sr_q[PAY_W-1];
        rd_sr_q <= {rd_sr_q[PAY_W-2:0], 1'b0};
      end else begin
        rd_sr_q <= '0;
      end
    end
  end

  assign miso = miso_q;
`endif

  assign adsr_ai   = ai_q;
  assign adsr_di   = di_q;
  assign adsr_s    = s_q;
  assign adsr_ri   = ri_q;
  assign osc_count = osc_q;
  assign filter_a  = fa_q;
  assign filter_b  = fb_q;
  assign progn     = progn_q;
  assign trig      = trig_q;
  assign frame_err = frame_err_q;

endmodule
